// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-select codes and FSM state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } hu_state_t;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Single execute-operand forward select. MEM wins over WB, and x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_mem,
    input  logic       i_me_we,
    input  logic [4:0] i_rd_wb,
    input  logic       i_wb_we,
    output logic [1:0] o_sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = i_me_we && (i_rd_mem != 5'd0) && (i_rd_mem == i_rs);
    assign w_hit_wb  = i_wb_we && (i_rd_wb  != 5'd0) && (i_rd_wb  == i_rs);

    // Priority select: the newer MEM result shadows the older WB one.
    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_mem)
            o_sel = FWD_MEM;
        else if (w_hit_wb)
            o_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// multicycle-op stall sequencing, plus a saturating count of decode stalls.
//
// state | meaning
// RUN   | normal issue; branch, load-use and multicycle start are evaluated
// MULTI | multicycle op occupying EX; pipeline frozen, CNT counts down
//
// The issue cycle of a multicycle op is itself the first stalled cycle, so an
// op of MULTI_LAT cycles spends MULTI_LAT-2 cycles in MULTI. A two-cycle op
// therefore stalls only in its issue cycle and never leaves RUN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_EX,
    input  logic [4:0]       RS2_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       RD_MEM,
    input  logic [4:0]       RD_WB,
    input  logic             DE_WE,
    input  logic             ME_WE,
    input  logic             WB_WE,
    input  logic             MEM_REG,
    input  logic             PC_R,
    input  logic             MULTI_START,
    input  logic [LAT_W-1:0] MULTI_LAT,
    output logic [1:0]       HU_RS1,
    output logic [1:0]       HU_RS2,
    output logic             STALL_F,
    output logic             STALL_D,
    output logic             STALL_E,
    output logic             FLUSH_D,
    output logic             FLUSH_E,
    output logic [CNT_W-1:0] STALL_CNT
);

    hu_state_t        r_state;
    hu_state_t        w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;
    logic [LAT_W-1:0] w_cnt_dec;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [1:0]       w_sel1;
    logic [1:0]       w_sel2;
    logic             w_load_use;
    logic             w_multi_go;
    logic             w_multi_long;

    fwd_sel u_fwd_rs1 (
        .i_rs     (RS1_EX),
        .i_rd_mem (RD_MEM),
        .i_me_we  (ME_WE),
        .i_rd_wb  (RD_WB),
        .i_wb_we  (WB_WE),
        .o_sel    (w_sel1)
    );

    fwd_sel u_fwd_rs2 (
        .i_rs     (RS2_EX),
        .i_rd_mem (RD_MEM),
        .i_me_we  (ME_WE),
        .i_rd_wb  (RD_WB),
        .i_wb_we  (WB_WE),
        .o_sel    (w_sel2)
    );

    assign HU_RS1 = rst ? FWD_RF : w_sel1;
    assign HU_RS2 = rst ? FWD_RF : w_sel2;

    assign w_load_use   = MEM_REG && DE_WE && (RD_EX != 5'd0) &&
                          ((RD_EX == RS1_D) || (RD_EX == RS2_D));
    assign w_multi_go   = MULTI_START && (MULTI_LAT > LAT_W'(1));
    assign w_multi_long = MULTI_LAT > LAT_W'(2);
    assign w_cnt_dec    = r_cnt - LAT_W'(1);

    // FSM state and multicycle down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and stall/flush decode; everything held low during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        STALL_F     = 1'b0;
        STALL_D     = 1'b0;
        STALL_E     = 1'b0;
        FLUSH_D     = 1'b0;
        FLUSH_E     = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (PC_R) begin
                        FLUSH_D = 1'b1;
                        FLUSH_E = 1'b1;
                    end else if (w_multi_go) begin
                        STALL_F = 1'b1;
                        STALL_D = 1'b1;
                        STALL_E = 1'b1;
                        if (w_multi_long) begin
                            w_state_nxt = MULTI;
                            w_cnt_nxt   = MULTI_LAT - LAT_W'(1);
                        end
                    end else if (w_load_use) begin
                        STALL_F = 1'b1;
                        STALL_D = 1'b1;
                        FLUSH_E = 1'b1;
                    end
                end
                MULTI: begin
                    STALL_F   = 1'b1;
                    STALL_D   = 1'b1;
                    STALL_E   = 1'b1;
                    w_cnt_nxt = w_cnt_dec;
                    if (w_cnt_dec == LAT_W'(1)) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (STALL_D && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign STALL_CNT = r_stall_cnt;

endmodule
